// File: rtl/scratchpad_port_arbiter.sv
// scratchpad_port_arbiter
//   Round-robin arbiter sharing one scratchpad memory channel between NUM_REQ
//   kernel ports (ce/we/addr/d/q style). One transaction in flight at a time.
// Ports:
//   mod_clk, reset          clock, async active-high reset
//   read_base, write_base   64-bit byte base addresses
//   req_ce/we/addr/d        per-port request (packed, port i at [i*W +: W])
//   req_ack, req_q          one-hot completion pulse, per-port held read data
//   mem_valid/ready/we/addr/wdata  request channel (valid/ready)
//   mem_rvalid, mem_rdata   read response strobe + data
//   busy, grant_id, access_count  status

// Per-port read-data holding register.
module scratchpad_port_qreg #(
  parameter int DATA_WID = 32
) (
  input  logic                mod_clk,
  input  logic                reset,
  input  logic                i_load,
  input  logic [DATA_WID-1:0] i_data,
  output logic [DATA_WID-1:0] o_q
);
  always_ff @(posedge mod_clk or posedge reset) begin
    if (reset)       o_q <= '0;
    else if (i_load) o_q <= i_data;
  end
endmodule

module scratchpad_port_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_WID = 14,
  parameter int DATA_WID = 32,
  parameter int GID_WID  = 2
) (
  input  logic                         mod_clk,
  input  logic                         reset,
  input  logic [63:0]                  read_base,
  input  logic [63:0]                  write_base,
  input  logic [NUM_REQ-1:0]           req_ce,
  input  logic [NUM_REQ-1:0]           req_we,
  input  logic [NUM_REQ*ADDR_WID-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WID-1:0]  req_d,
  output logic [NUM_REQ-1:0]           req_ack,
  output logic [NUM_REQ*DATA_WID-1:0]  req_q,
  output logic                         mem_valid,
  input  logic                         mem_ready,
  output logic                         mem_we,
  output logic [63:0]                  mem_addr,
  output logic [DATA_WID-1:0]          mem_wdata,
  input  logic                         mem_rvalid,
  input  logic [DATA_WID-1:0]          mem_rdata,
  output logic                         busy,
  output logic [GID_WID-1:0]           grant_id,
  output logic [31:0]                  access_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT_RSP, ST_ACK} state_t;

  state_t               r_state;
  logic [GID_WID-1:0]   r_ptr;

  logic [NUM_REQ-1:0][ADDR_WID-1:0] w_addr_arr;
  logic [NUM_REQ-1:0][DATA_WID-1:0] w_d_arr;
  logic                 w_any;
  logic [GID_WID-1:0]   w_sel;
  logic [GID_WID-1:0]   w_idx;
  logic [63:0]          w_base;
  logic [63:0]          w_off;
  logic [NUM_REQ-1:0]   w_gnt_oh;
  logic [NUM_REQ-1:0]   w_qload;

  assign w_addr_arr = req_addr;
  assign w_d_arr    = req_d;

  // Scan from farthest to nearest offset so the first set bit after r_ptr
  // (lowest offset) is the last one written and wins.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    w_idx = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      w_idx = GID_WID'((int'(r_ptr) + off) % NUM_REQ);
      if (req_ce[w_idx]) begin
        w_any = 1'b1;
        w_sel = w_idx;
      end
    end
  end

  assign w_base   = req_we[w_sel] ? write_base : read_base;
  assign w_off    = {{(62-ADDR_WID){1'b0}}, w_addr_arr[w_sel], 2'b00};
  assign w_gnt_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;
  assign busy     = (r_state != ST_IDLE);

  // Read data lands only while waiting for the response of the granted port;
  // responses seen in any other state (including after reset) are dropped.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_port
      assign w_qload[gi] = (r_state == ST_WAIT_RSP) && mem_rvalid &&
                           (grant_id == GID_WID'(gi));
      scratchpad_port_qreg #(.DATA_WID(DATA_WID)) u_qreg (
        .mod_clk (mod_clk),
        .reset   (reset),
        .i_load  (w_qload[gi]),
        .i_data  (mem_rdata),
        .o_q     (req_q[gi*DATA_WID +: DATA_WID])
      );
    end
  endgenerate

  // req_ack, access_count and ptr update on the edge entering ACK so the
  // ack pulse, the new count and the read data all show in the same cycle.
  always_ff @(posedge mod_clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_ptr        <= GID_WID'(NUM_REQ-1);
      mem_valid    <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      req_ack      <= '0;
      grant_id     <= '0;
      access_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            grant_id  <= w_sel;
            mem_we    <= req_we[w_sel];
            mem_wdata <= w_d_arr[w_sel];
            mem_addr  <= w_base + w_off;
            mem_valid <= 1'b1;
            r_state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            if (mem_we) begin
              req_ack      <= w_gnt_oh;
              access_count <= access_count + 32'd1;
              r_ptr        <= grant_id;
              r_state      <= ST_ACK;
            end else begin
              r_state <= ST_WAIT_RSP;
            end
          end
        end
        ST_WAIT_RSP: begin
          if (mem_rvalid) begin
            req_ack      <= w_gnt_oh;
            access_count <= access_count + 32'd1;
            r_ptr        <= grant_id;
            r_state      <= ST_ACK;
          end
        end
        ST_ACK: begin
          req_ack <= '0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scratchpad_port_arbiter.sv
// Directed bench for scratchpad_port_arbiter: inputs driven and outputs
// sampled 1 time unit after each rising edge.
module tb_scratchpad_port_arbiter;
  localparam int NR = 4, AW = 14, DW = 32, GW = 2;

  logic          mod_clk = 1'b0;
  logic          reset;
  logic [63:0]   read_base, write_base;
  logic [NR-1:0] req_ce, req_we;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_d;
  logic [NR-1:0] req_ack;
  logic [NR*DW-1:0] req_q;
  logic          mem_valid, mem_ready, mem_we;
  logic [63:0]   mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic [GW-1:0] grant_id;
  logic [31:0]   access_count;

  int n_chk = 0;
  int n_err = 0;

  scratchpad_port_arbiter #(.NUM_REQ(NR), .ADDR_WID(AW), .DATA_WID(DW), .GID_WID(GW)) dut (
    .mod_clk(mod_clk), .reset(reset), .read_base(read_base), .write_base(write_base),
    .req_ce(req_ce), .req_we(req_we), .req_addr(req_addr), .req_d(req_d),
    .req_ack(req_ack), .req_q(req_q), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy),
    .grant_id(grant_id), .access_count(access_count)
  );

  always #5 mod_clk = ~mod_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge mod_clk);
    #1;
  endtask

  function automatic logic [DW-1:0] q_of(input int p);
    return req_q[p*DW +: DW];
  endfunction

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!mem_valid && n < 10) begin
      tick();
      n++;
    end
    chk(tag, mem_valid, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    read_base = '0; write_base = '0;
    req_ce = '0; req_we = '0; req_addr = '0; req_d = '0;
    mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
    do_reset();

    // reset state
    chk("rst_valid", mem_valid, 0);
    chk("rst_addr",  mem_addr, 0);
    chk("rst_ack",   req_ack, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_cnt",   access_count, 0);
    chk("rst_q",     req_q, 0);

    // port 0 write, ready high
    write_base = 64'h1000;
    req_ce = 4'b0001; req_we = 4'b0001;
    req_addr[0*AW +: AW] = 14'h0005;
    req_d[0*DW +: DW] = 32'hDEADBEEF;
    tick();
    chk("w_valid", mem_valid, 1);
    chk("w_we",    mem_we, 1);
    chk("w_addr",  mem_addr, 64'h1014);
    chk("w_wdata", mem_wdata, 32'hDEADBEEF);
    chk("w_ack0",  req_ack, 0);
    chk("w_busy",  busy, 1);
    tick();
    req_ce = '0;
    chk("w_vdrop", mem_valid, 0);
    chk("w_ack",   req_ack, 4'b0001);
    chk("w_cnt",   access_count, 1);
    tick();
    chk("w_ackclr", req_ack, 0);
    chk("w_idle",   busy, 0);

    // port 2 read with delayed response; inputs changed while in flight
    read_base = 64'h2000;
    req_ce = 4'b0100; req_we = 4'b0000;
    req_addr[2*AW +: AW] = 14'h3FFF;
    tick();
    chk("r_addr", mem_addr, 64'h11FFC);
    chk("r_we",   mem_we, 0);
    chk("r_gid",  grant_id, 2);
    req_ce = '0; req_addr[2*AW +: AW] = 14'h0001; read_base = 64'h0;
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;  // in accept cycle: must be ignored
    tick();
    mem_rvalid = 1'b0;
    chk("r_vdrop", mem_valid, 0);
    chk("r_noack1", req_ack, 0);
    tick();
    tick();
    chk("r_noack2", req_ack, 0);
    chk("r_q_pre", q_of(2), 0);
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    tick();
    mem_rvalid = 1'b0;
    chk("r_ack", req_ack, 4'b0100);
    chk("r_q",   q_of(2), 32'h12345678);
    chk("r_cnt", access_count, 2);
    tick();
    chk("r_ackclr", req_ack, 0);
    chk("r_qhold",  q_of(2), 32'h12345678);

    // port 1 write with mem_ready low for 5 cycles
    write_base = 64'h1000;
    mem_ready = 1'b0;
    req_ce = 4'b0010; req_we = 4'b0010;
    req_addr[1*AW +: AW] = 14'h0010;
    req_d[1*DW +: DW] = 32'hCAFEF00D;
    tick();
    chk("s_addr", mem_addr, 64'h1040);
    req_ce = '0; req_d[1*DW +: DW] = 32'h0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("s_valid%0d", i), mem_valid, 1);
      chk($sformatf("s_addr%0d", i),  mem_addr, 64'h1040);
      chk($sformatf("s_wdata%0d", i), mem_wdata, 32'hCAFEF00D);
      chk($sformatf("s_noack%0d", i), req_ack, 0);
    end
    mem_ready = 1'b1;
    tick();
    chk("s_ack",   req_ack, 4'b0010);
    chk("s_vdrop", mem_valid, 0);
    chk("s_cnt",   access_count, 3);
    tick();

    // 64-bit address wrap, port 3 read
    read_base = 64'hFFFF_FFFF_FFFF_FFFC;
    req_ce = 4'b1000; req_we = 4'b0000;
    req_addr[3*AW +: AW] = 14'h0002;
    tick();
    chk("x_addr", mem_addr, 64'h4);
    req_ce = '0;
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_55AA;
    tick();
    mem_rvalid = 1'b0;
    chk("x_ack", req_ack, 4'b1000);
    chk("x_q",   q_of(3), 32'h55AA);
    tick();

    // all ports reading continuously after reset: 0,1,2,3,0,1
    do_reset();
    read_base = 64'h0;
    req_ce = 4'b1111; req_we = 4'b0000;
    for (int k = 0; k < 6; k++) begin
      wait_valid($sformatf("rr_to%0d", k));
      chk($sformatf("rr_gid%0d", k), grant_id, k % 4);
      tick();
      mem_rvalid = 1'b1; mem_rdata = 32'hA0 + k;
      tick();
      mem_rvalid = 1'b0;
      chk($sformatf("rr_ack%0d", k), req_ack, 4'b0001 << (k % 4));
      chk($sformatf("rr_q%0d", k), q_of(k % 4), 32'hA0 + k);
    end
    chk("rr_cnt", access_count, 6);
    req_ce = '0;
    tick();
    tick();

    // reset while in WAIT_RSP, then a stale response
    do_reset();
    req_ce = 4'b0010; req_we = 4'b0000;
    tick();
    req_ce = '0;
    tick();
    chk("a_busy_pre", busy, 1);
    reset = 1'b1;
    #1;
    chk("a_busy_rst", busy, 0);
    tick();
    reset = 1'b0;
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    tick();
    mem_rvalid = 1'b0;
    chk("a_noack1", req_ack, 0);
    tick();
    chk("a_noack2", req_ack, 0);
    chk("a_q",      req_q, 0);
    chk("a_busy",   busy, 0);
    chk("a_cnt",    access_count, 0);
    chk("a_valid",  mem_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
